// File: rtl/alu_operand_loader_if.sv
// Bundle of the loader's upstream beat bus, ALU drive/return lines and
// downstream result handshake. "slave" is the loader's view, "master" is
// the surrounding environment (upstream source, ALU and result sink).
interface alu_operand_loader_if #(
    parameter int unsigned ANCHO = 4
);
    // Upstream operand/command beats
    logic [ANCHO-1:0] dato_in;
    logic [4:0]       cmd_in;
    logic             dato_valid;
    logic             dato_ready;

    // ALU drive and combinational return
    logic [ANCHO-1:0] ALUA;
    logic [ANCHO-1:0] ALUB;
    logic             ALUFlagIn;
    logic [3:0]       ALUControl;
    logic [ANCHO-1:0] ALUResult;
    logic             ALUFlags;
    logic             ALUZero;

    // Downstream result handshake
    logic [ANCHO-1:0] res_out;
    logic             flag_out;
    logic             zero_out;
    logic             op_error;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       ops_count;

    modport slave (
        input  dato_in, cmd_in, dato_valid,
        output dato_ready,
        output ALUA, ALUB, ALUFlagIn, ALUControl,
        input  ALUResult, ALUFlags, ALUZero,
        output res_out, flag_out, zero_out, op_error, res_valid, ops_count,
        input  res_ready
    );

    modport master (
        output dato_in, cmd_in, dato_valid,
        input  dato_ready,
        input  ALUA, ALUB, ALUFlagIn, ALUControl,
        output ALUResult, ALUFlags, ALUZero,
        input  res_out, flag_out, zero_out, op_error, res_valid, ops_count,
        output res_ready
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Front-end stage for the combinational ALU: loads A, B and a command over a
// valid/ready beat bus, lets the ALU settle one cycle, registers its result
// and offers it downstream on a second valid/ready handshake.
module alu_operand_loader #(
    parameter int unsigned ANCHO = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_operand_loader_if.slave bus
);

    typedef enum logic [2:0] {StA, StB, StCmd, StExec, StOut} state_e;

    localparam logic [3:0] MaxLegalCode = 4'h9;

    state_e           state_q, state_d;
    logic [ANCHO-1:0] alu_a_q, alu_a_d;
    logic [ANCHO-1:0] alu_b_q, alu_b_d;
    logic             flag_in_q, flag_in_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [ANCHO-1:0] res_q, res_d;
    logic             flag_q, flag_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             dato_ready_q, dato_ready_d;
    logic             res_valid_q, res_valid_d;

    logic             beat;

    // Beat transfers only when the registered ready is up, so the first cycle
    // after reset never consumes a beat.
    assign beat = bus.dato_valid && dato_ready_q;

    // Next-state, operand capture and result capture.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        flag_in_d = flag_in_q;
        ctrl_d    = ctrl_q;
        res_d     = res_q;
        flag_d    = flag_q;
        zero_d    = zero_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            StA: begin
                if (beat) begin
                    alu_a_d = bus.dato_in;
                    state_d = StB;
                end
            end
            StB: begin
                if (beat) begin
                    alu_b_d = bus.dato_in;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (beat) begin
                    ctrl_d    = bus.cmd_in[3:0];
                    flag_in_d = bus.cmd_in[4];
                    state_d   = StExec;
                end
            end
            StExec: begin
                // Illegal codes leave the ALU outputs undefined; never sample them.
                if (ctrl_q <= MaxLegalCode) begin
                    res_d  = bus.ALUResult;
                    flag_d = bus.ALUFlags;
                    zero_d = bus.ALUZero;
                    err_d  = 1'b0;
                end else begin
                    res_d  = '0;
                    flag_d = 1'b0;
                    zero_d = 1'b0;
                    err_d  = 1'b1;
                end
                state_d = StOut;
            end
            StOut: begin
                if (bus.res_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = StA;
                end
            end
            default: state_d = StA;
        endcase
        // Handshake outputs are registered decodes of the next state.
        dato_ready_d = (state_d == StA) || (state_d == StB) || (state_d == StCmd);
        res_valid_d  = (state_d == StOut);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StA;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            flag_in_q    <= 1'b0;
            ctrl_q       <= 4'h0;
            res_q        <= '0;
            flag_q       <= 1'b0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 8'd0;
            dato_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            flag_in_q    <= flag_in_d;
            ctrl_q       <= ctrl_d;
            res_q        <= res_d;
            flag_q       <= flag_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            dato_ready_q <= dato_ready_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign bus.dato_ready = dato_ready_q;
    assign bus.ALUA       = alu_a_q;
    assign bus.ALUB       = alu_b_q;
    assign bus.ALUFlagIn  = flag_in_q;
    assign bus.ALUControl = ctrl_q;
    assign bus.res_out    = res_q;
    assign bus.flag_out   = flag_q;
    assign bus.zero_out   = zero_q;
    assign bus.op_error   = err_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.ops_count  = cnt_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a small behavioural ALU.
module tb_alu_operand_loader;

    localparam int unsigned ANCHO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   edges = 0;

    alu_operand_loader_if #(.ANCHO(ANCHO)) bus ();

    alu_operand_loader #(.ANCHO(ANCHO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    // Behavioural ALU: [ANCHO] of wide is the carry/shift-out flag.
    logic [ANCHO:0] wide;
    always_comb begin
        wide = '0;
        case (bus.ALUControl)
            4'h0: wide = {1'b0, bus.ALUA & bus.ALUB};
            4'h1: wide = {1'b0, bus.ALUA | bus.ALUB};
            4'h2: wide = {1'b0, bus.ALUA} + {1'b0, bus.ALUB} + {{ANCHO{1'b0}}, bus.ALUFlagIn};
            4'h3: wide = {1'b0, bus.ALUA} - {1'b0, bus.ALUB};
            4'h4: wide = {1'b0, bus.ALUA ^ bus.ALUB};
            4'h5: wide = {1'b0, ~bus.ALUA};
            4'h6: wide = {bus.ALUA, 1'b0};
            4'h7: wide = {bus.ALUA[0], 1'b0, bus.ALUA[ANCHO-1:1]};
            4'h8: wide = {1'b0, bus.ALUA};
            4'h9: wide = {1'b0, bus.ALUB};
            default: wide = 'x;
        endcase
        bus.ALUResult = wide[ANCHO-1:0];
        bus.ALUFlags  = wide[ANCHO];
        bus.ALUZero   = (wide[ANCHO-1:0] == '0);
    end

    task automatic send_beat(input logic [3:0] d, input logic [4:0] c);
        int n = 0;
        bus.dato_valid = 1'b1;
        bus.dato_in    = d;
        bus.cmd_in     = c;
        while (!bus.dato_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.dato_ready) begin
            total++; bad++;
            $display("FAIL beat_timeout dato_ready=%0b required=1", bus.dato_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic load_op(input logic [3:0] a, input logic [3:0] b, input logic [4:0] c);
        send_beat(a, 5'h00);
        send_beat(b, 5'h00);
        send_beat(4'hE, c);
        bus.dato_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.res_valid) begin
            total++; bad++;
            $display("FAIL result_timeout res_valid=%0b required=1", bus.res_valid);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #11;
        total++;
        if ({bus.ALUA, bus.ALUB, bus.ALUFlagIn, bus.ALUControl} !== 13'h0) begin
            bad++;
            $display("FAIL reset_alu_drive got=%h required=0",
                     {bus.ALUA, bus.ALUB, bus.ALUFlagIn, bus.ALUControl});
        end
        total++;
        if ({bus.res_out, bus.flag_out, bus.zero_out, bus.op_error, bus.res_valid} !== 8'h0) begin
            bad++;
            $display("FAIL reset_result got=%h required=0",
                     {bus.res_out, bus.flag_out, bus.zero_out, bus.op_error, bus.res_valid});
        end
        total++;
        if (bus.ops_count !== 8'd0) begin
            bad++; $display("FAIL reset_count got=%0d required=0", bus.ops_count);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.dato_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%0b required=1", bus.dato_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        load_op(4'h3, 4'h5, 5'b0_0010);
        total++;
        if ({bus.res_valid, bus.ALUControl} !== 5'b0_0010) begin
            bad++;
            $display("FAIL add_after_cmd valid_ctrl=%b required=00010",
                     {bus.res_valid, bus.ALUControl});
        end
        wait_result(lat);
        total++;
        if (lat != 1) begin
            bad++; $display("FAIL add_latency got=%0d required=1", lat);
        end
        total++;
        if ({bus.res_out, bus.flag_out, bus.zero_out, bus.op_error} !== 7'b1000_000) begin
            bad++;
            $display("FAIL add_result got=%b required=1000000",
                     {bus.res_out, bus.flag_out, bus.zero_out, bus.op_error});
        end
        @(posedge clk); #1;
        total++;
        if ({bus.ops_count, bus.res_valid, bus.res_out} !== {8'd1, 1'b0, 4'h8}) begin
            bad++;
            $display("FAIL add_ack count=%0d valid=%0b res=%h required 1,0,8",
                     bus.ops_count, bus.res_valid, bus.res_out);
        end
    endtask

    task automatic test_and();
        int lat;
        load_op(4'hC, 4'h3, 5'b0_0000);
        wait_result(lat);
        total++;
        if ({bus.res_out, bus.flag_out, bus.zero_out, bus.op_error} !== 7'b0000_010) begin
            bad++;
            $display("FAIL and_result got=%b required=0000010",
                     {bus.res_out, bus.flag_out, bus.zero_out, bus.op_error});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_carry();
        int lat;
        load_op(4'hF, 4'h1, 5'b1_0010);
        wait_result(lat);
        total++;
        if ({bus.ALUFlagIn, bus.res_out, bus.flag_out, bus.zero_out, bus.op_error}
                !== 8'b1_0001_100) begin
            bad++;
            $display("FAIL carry_result got=%b required=10001100",
                     {bus.ALUFlagIn, bus.res_out, bus.flag_out, bus.zero_out, bus.op_error});
        end
        @(posedge clk); #1;
        total++;
        if (bus.ops_count !== 8'd3) begin
            bad++; $display("FAIL carry_count got=%0d required=3", bus.ops_count);
        end
    endtask

    task automatic test_illegal();
        int lat;
        load_op(4'h2, 4'h1, 5'b0_1010);
        wait_result(lat);
        total++;
        if ({bus.ALUControl, bus.res_out, bus.flag_out, bus.zero_out, bus.op_error}
                !== 11'b1010_0000_001) begin
            bad++;
            $display("FAIL illegal_result got=%b required=10100000001",
                     {bus.ALUControl, bus.res_out, bus.flag_out, bus.zero_out, bus.op_error});
        end
        @(posedge clk); #1;
        total++;
        if (bus.ops_count !== 8'd4) begin
            bad++; $display("FAIL illegal_count got=%0d required=4", bus.ops_count);
        end
    endtask

    task automatic test_hold();
        int lat;
        bus.res_ready = 1'b0;
        load_op(4'h6, 4'h7, 5'b0_0010);
        wait_result(lat);
        bus.dato_valid = 1'b1;
        bus.dato_in    = 4'h9;
        bus.cmd_in     = 5'h1F;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total++;
            if ({bus.res_valid, bus.dato_ready, bus.res_out, bus.flag_out, bus.zero_out,
                 bus.op_error} !== 9'b1_0_1101_000) begin
                bad++;
                $display("FAIL hold_stable cycle=%0d got=%b required=101101000", k,
                         {bus.res_valid, bus.dato_ready, bus.res_out, bus.flag_out,
                          bus.zero_out, bus.op_error});
            end
        end
        total++;
        if (bus.ops_count !== 8'd4) begin
            bad++; $display("FAIL hold_count got=%0d required=4", bus.ops_count);
        end
        bus.dato_valid = 1'b0;
        bus.res_ready  = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.dato_ready, bus.ops_count, bus.ALUA, bus.ALUControl}
                !== {1'b1, 8'd5, 4'h6, 4'h2}) begin
            bad++;
            $display("FAIL hold_release ready=%0b count=%0d a=%h ctrl=%h required 1,5,6,2",
                     bus.dato_ready, bus.ops_count, bus.ALUA, bus.ALUControl);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        send_beat(4'h5, 5'h00);
        send_beat(4'hA, 5'h00);
        bus.dato_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.ALUA, bus.ALUB, bus.res_out, bus.ops_count, bus.dato_ready} !== 21'h0) begin
            bad++;
            $display("FAIL midreset_clear a=%h b=%h res=%h count=%0d ready=%0b required 0",
                     bus.ALUA, bus.ALUB, bus.res_out, bus.ops_count, bus.dato_ready);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        load_op(4'h1, 4'h2, 5'b0_0010);
        wait_result(lat);
        total++;
        if ({bus.ALUA, bus.ALUB, bus.res_out, bus.op_error} !== {4'h1, 4'h2, 4'h3, 1'b0}) begin
            bad++;
            $display("FAIL midreset_op a=%h b=%h res=%h err=%0b required 1,2,3,0",
                     bus.ALUA, bus.ALUB, bus.res_out, bus.op_error);
        end
        @(posedge clk); #1;
        total++;
        if (bus.ops_count !== 8'd1) begin
            bad++; $display("FAIL midreset_count got=%0d required=1", bus.ops_count);
        end
    endtask

    // Count is 1 on entry, so 255 more ops wrap it to 0.
    task automatic test_back_to_back();
        int lat;
        int start;
        logic [3:0] a;
        logic [3:0] want;
        int wrong = 0;
        start = edges;
        for (int i = 0; i < 255; i++) begin
            a    = i[3:0];
            want = a + 4'h3;
            load_op(a, 4'h3, 5'b0_0010);
            wait_result(lat);
            if (bus.res_out !== want) wrong++;
            if (i == 254) begin
                total++;
                if (bus.ops_count !== 8'd255) begin
                    bad++; $display("FAIL b2b_pre_wrap got=%0d required=255", bus.ops_count);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (wrong != 0) begin
            bad++; $display("FAIL b2b_results wrong=%0d required=0", wrong);
        end
        total++;
        if (bus.ops_count !== 8'd0) begin
            bad++; $display("FAIL b2b_wrap got=%0d required=0", bus.ops_count);
        end
        total++;
        if (edges - start != 255 * 5) begin
            bad++; $display("FAIL b2b_throughput cycles=%0d required=%0d", edges - start, 255 * 5);
        end
    endtask

    initial begin
        bus.dato_valid = 1'b0;
        bus.dato_in    = '0;
        bus.cmd_in     = '0;
        bus.res_ready  = 1'b1;
        test_reset();
        test_add();
        test_and();
        test_carry();
        test_illegal();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
